// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one 4-bit ALU between two requesters. A request is accepted in
//   IDLE via valid/ready. Its operands are registered onto the ALU inputs,
//   and the ALU result is captured one cycle later. The result is then
//   presented with the owning requester ID until the consumer accepts it.
//
// Ports
//   clk, reset                 clock (rising edge), async active-high reset
//   reqN_valid / reqN_ready    request handshake for requester N (N = 0, 1)
//   reqN_a, reqN_b             operands A and B (4 bits)
//   reqN_c                     shift amount (2 bits)
//   reqN_op                    opcode (2 bits)
//   alu_inA/inB/inC/op         registered drive to the ALU instance
//   alu_ans                    combinational result from the ALU
//   rsp_valid / rsp_ready      response handshake
//   rsp_data, rsp_id           captured result and the ID of its owner
//
// Build option
//   ALU_ARB_FIXED_PRIO_EN      when defined, requester 0 always wins a tie.
//                              When undefined, ties are resolved round-robin.
module alu_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [1:0] req0_c,
  input  logic [1:0] req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [1:0] req1_c,
  input  logic [1:0] req1_op,
  output logic [3:0] alu_inA,
  output logic [3:0] alu_inB,
  output logic [1:0] alu_inC,
  output logic [1:0] alu_op,
  input  logic [3:0] alu_ans,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_data,
  output logic       rsp_id
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state;
  logic   lastGrant;
  logic   anyValid;
  logic   grantId;

  // Grant selection. It is only meaningful in IDLE, where the ready outputs
  // are gated.
  always_comb begin
    anyValid = req0_valid | req1_valid;
    grantId  = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      grantId = 1'b0;
`else
      grantId = ~lastGrant;
`endif
    end else if (req1_valid) begin
      grantId = 1'b1;
    end
  end

  assign req0_ready = (state == IDLE) && anyValid && !grantId;
  assign req1_ready = (state == IDLE) && anyValid &&  grantId;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      alu_inA   <= '0;
      alu_inB   <= '0;
      alu_inC   <= '0;
      alu_op    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
      lastGrant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (anyValid) begin
            if (grantId) begin
              alu_inA <= req1_a;
              alu_inB <= req1_b;
              alu_inC <= req1_c;
              alu_op  <= req1_op;
            end else begin
              alu_inA <= req0_a;
              alu_inB <= req0_b;
              alu_inC <= req0_c;
              alu_op  <= req0_op;
            end
            lastGrant <= grantId;
            rsp_id    <= grantId;
            state     <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= alu_ans;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 4-bit ALU (ops: 00 arithmetic shift right by inC, 01 logical shift right by inC, 10 inA-inB, 11 inA+inB) between two requesters.
- Each requester issues one operation through a valid/ready handshake.
- The block registers the operands, drives the ALU, captures the result, and returns it tagged with the requester ID through a second valid/ready handshake.
- It sits between the two ALU clients and the ALU instance.

Parameters:
- none (all widths are fixed by the ALU: A/B 4 bits, shift amount 2 bits, op 2 bits)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation pending
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a  in  4  requester 0 operand A
- req0_b  in  4  requester 0 operand B
- req0_c  in  2  requester 0 shift amount
- req0_op  in  2  requester 0 opcode
- req1_valid, req1_ready, req1_a, req1_b, req1_c, req1_op  same widths/meaning for requester 1
- alu_inA  out  4  to ALU inA
- alu_inB  out  4  to ALU inB
- alu_inC  out  2  to ALU inC
- alu_op  out  2  to ALU op
- alu_ans  in  4  from ALU ans (combinational)
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  4  captured ALU result
- rsp_id  out  1  requester that owns rsp_data (0 or 1)

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state=IDLE; alu_inA/inB/inC/op=0; rsp_valid=0; rsp_data=0; rsp_id=0; last_grant=1, so requester 0 wins the first tie.
- Ready outputs: req0_ready and req1_ready are combinational and are 0 outside IDLE.
- FSM: three states, IDLE, EXEC and RESP.
- IDLE, no valid request: stay in IDLE. Outputs hold their values.
- IDLE, one or more requests valid:
  - Pick the grant. If only one requester is valid, grant it. If both are valid, grant the requester != last_grant (round-robin).
  - Assert reqN_ready for the granted requester only, in the same cycle. The handshake completes on that edge.
  - Register that requester's a/b/c/op into alu_inA/inB/inC/op.
  - Set last_grant and rsp_id to the granted ID.
  - Go to EXEC.
- EXEC: the ALU output is settled. On the edge, rsp_data <= alu_ans, rsp_valid <= 1, go to RESP. Fixed 1 cycle in this state.
- RESP:
  - rsp_valid=1. rsp_data and rsp_id are held stable until accepted.
  - If rsp_ready=1: rsp_valid <= 0 on the edge, go to IDLE.
  - If rsp_ready=0: stay in RESP indefinitely.
- Timing: latency from request acceptance to rsp_valid is 2 cycles. Minimum issue interval is 3 cycles when rsp_ready is held high.
- ALU inputs are held at the last issued values in RESP and IDLE; they are not cleared after each operation.
- Requests that are not granted are not accepted. Requesters must hold valid and payload until ready is asserted.
- A request whose valid drops before grant is ignored, with no side effects.
- Arithmetic: all results are 4-bit modulo, as computed by the ALU. The block never alters alu_ans.
- Reset asserted in EXEC or RESP: the in-flight operation is discarded, rsp_valid drops immediately, and the block returns to IDLE with reset values.
- Opcode: req_op is passed through unchecked. All four codes are legal.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- When defined: requester 0 always wins when both are valid. last_grant is still updated but is ignored for arbitration.
- When undefined (default): round-robin as described in Behaviour.

Test Plan:
- Single add: req0 with a=3, b=5, op=11, rsp_ready=1. Expected: req0_ready=1 in cycle 0; rsp_valid=1 in cycle 2 with rsp_data=8, rsp_id=0.
- Shifts and subtract on req1:
  - a=4'b1000, c=2, op=00 -> rsp_data=4'b1110.
  - same operands, op=01 -> rsp_data=4'b0010.
  - a=2, b=5, op=10 -> rsp_data=4'b1101.
- Contention: req0 and req1 both held valid for 4 operations. Expected grant order 0,1,0,1. With ALU_ARB_FIXED_PRIO_EN defined, expected order 0,0,0,0.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid. Expected: rsp_valid, rsp_data and rsp_id stay stable, req0_ready and req1_ready stay 0, and no new grant occurs. After rsp_ready=1, the block is back in IDLE next cycle.
- Reset mid-operation: assert reset during EXEC. Expected: rsp_valid=0 and alu_op=0 immediately. After release, the next request is granted normally and requester 0 wins a tie.
- Dropped request: req1_valid is high for 1 cycle while the block is in RESP, then goes low. Expected: req1 is never granted and no response carries rsp_id=1.
